// File: rtl/seg_frame_reader.sv
// Seven-segment bus readback: samples the active-low anode/segment lines, decodes each digit
// back to BCD and publishes one complete frame per scan. Define SEG_RX_BLANK_EN to accept 1111111 as a legal blank.
module seg_frame_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    glitch
);

    localparam int             IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]     CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]     CAP_AT  = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {ST_HUNT, ST_SETTLE, ST_HELD} state_t;

    logic [NUM_DIGITS-1:0] r_an_q, r_an_d;
    logic [6:0]            r_seg_q, r_seg_d;
    logic [7:0]            r_cnt;
    state_t                r_state, w_state_nxt;
    logic [3:0]            r_slot [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_seen, w_seen_nxt;
    logic                  r_err_acc, w_err_nxt;

    logic                  w_onehot, w_chg, w_cap, w_glitch, w_illegal, w_complete;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_digit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) w_idx = IDX_W'(i);
        end
        w_onehot   = ($countones(~r_an_q) == 1);
        w_chg      = (r_an_q != r_an_d) || (r_seg_q != r_seg_d);
        w_complete = &r_seen;
    end

    always_comb begin
        w_illegal = 1'b0;
        case (r_seg_q)
            7'b1000000: w_digit = 4'd0;
            7'b1111001: w_digit = 4'd1;
            7'b0100100: w_digit = 4'd2;
            7'b0110000: w_digit = 4'd3;
            7'b0011001: w_digit = 4'd4;
            7'b0010010: w_digit = 4'd5;
            7'b0000010: w_digit = 4'd6;
            7'b1111000: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0010000: w_digit = 4'd9;
`ifdef SEG_RX_BLANK_EN
            7'b1111111: w_digit = 4'hF;
`endif
            default: begin
                w_digit   = 4'hE;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Dwell FSM: capture once per steady one-hot dwell, flag changes that abort a settling digit.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_glitch    = 1'b0;
        if (!w_onehot) begin
            w_state_nxt = ST_HUNT;
        end else if (w_chg || r_state == ST_HUNT) begin
            w_state_nxt = ST_SETTLE;
        end else if (r_state == ST_SETTLE && r_cnt == CAP_AT) begin
            w_state_nxt = ST_HELD;
            w_cap       = 1'b1;
        end
        if (w_chg && r_state == ST_SETTLE && r_cnt != 8'd0) w_glitch = 1'b1;
    end

    // A completing frame releases seen/err_acc first; a same-cycle capture starts the next frame.
    always_comb begin
        w_seen_nxt = w_complete ? '0 : r_seen;
        w_err_nxt  = w_complete ? 1'b0 : r_err_acc;
        if (w_cap) begin
            w_seen_nxt[w_idx] = 1'b1;
            w_err_nxt         = w_err_nxt | w_illegal;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_q      <= '1;
            r_an_d      <= '1;
            r_seg_q     <= '1;
            r_seg_d     <= '1;
            r_cnt       <= '0;
            r_state     <= ST_HUNT;
            r_seen      <= '0;
            r_err_acc   <= 1'b0;
            bcd_out     <= '1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            glitch      <= 1'b0;
        end else begin
            r_an_q      <= an;
            r_an_d      <= r_an_q;
            r_seg_q     <= seg;
            r_seg_d     <= r_seg_q;
            r_state     <= w_state_nxt;
            r_seen      <= w_seen_nxt;
            r_err_acc   <= w_err_nxt;
            glitch      <= w_glitch;
            frame_valid <= w_complete;
            if (!w_onehot || w_chg) r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
            if (w_complete) begin
                for (int i = 0; i < NUM_DIGITS; i++) bcd_out[4*i +: 4] <= r_slot[i];
                frame_err <= r_err_acc;
            end
        end
    end

    // NOTE: the slot memory is reset so a frame interrupted by reset never leaks stale digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_slot[i] <= 4'hF;
        end else if (w_cap) begin
            r_slot[w_idx] <= w_digit;
        end
    end

endmodule

// File: tb/tb_seg_frame_reader.sv
// Directed bench for seg_frame_reader (NUM_DIGITS=4, STABLE_CYCLES=16); expectations follow SEG_RX_BLANK_EN.
module tb_seg_frame_reader;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_BAD   = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] bcd_out;
    logic        frame_valid, frame_err, glitch;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int gl_cnt  = 0;
    int fv_base;

    seg_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .bcd_out(bcd_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .glitch(glitch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && frame_valid) fv_cnt++;
        if (!rst && glitch) gl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int cycles);
        an      = 4'b1111;
        an[idx] = 1'b0;
        seg     = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input int cycles);
        an  = a;
        seg = s;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        seg = SEG_BLANK;
        repeat (3) @(negedge clk);
        check("reset_bcd", 32'(bcd_out), 32'h0000_FFFF);
        check("reset_fv", 32'(frame_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_glitch", 32'(glitch), 32'd0);
        rst = 1'b0;
        drive_raw(4'b1111, SEG_BLANK, 4);

        // Clean scan 2,0,2,5 on an[3..0]
        show(3, SEG_2, 20); show(2, SEG_0, 20); show(1, SEG_2, 20); show(0, SEG_5, 20);
        check("scan1_fv_count", 32'(fv_cnt), 32'd1);
        check("scan1_bcd", 32'(bcd_out), 32'h0000_2025);
        check("scan1_ferr", 32'(frame_err), 32'd0);
        check("scan1_no_glitch", 32'(gl_cnt), 32'd0);

        // Illegal pattern in slot 1
        show(3, SEG_2, 20); show(2, SEG_0, 20); show(1, SEG_BAD, 20); show(0, SEG_5, 20);
        check("bad_fv_count", 32'(fv_cnt), 32'd2);
        check("bad_bcd", 32'(bcd_out), 32'h0000_20E5);
        check("bad_ferr", 32'(frame_err), 32'd1);

        // A clean scan afterwards clears the error
        show(3, SEG_2, 20); show(2, SEG_0, 20); show(1, SEG_2, 20); show(0, SEG_5, 20);
        check("clean_fv_count", 32'(fv_cnt), 32'd3);
        check("clean_bcd", 32'(bcd_out), 32'h0000_2025);
        check("clean_ferr", 32'(frame_err), 32'd0);

        // Short dwell on an[2] aborts with a glitch; frame waits for a proper an[2] dwell
        show(3, SEG_6, 20); show(2, SEG_3, 10); show(1, SEG_8, 20); show(0, SEG_1, 20);
        check("short_glitch", 32'(gl_cnt), 32'd1);
        check("short_no_frame", 32'(fv_cnt), 32'd3);
        check("short_bcd_hold", 32'(bcd_out), 32'h0000_2025);
        show(2, SEG_3, 20);
        check("short_fv_count", 32'(fv_cnt), 32'd4);
        check("short_bcd", 32'(bcd_out), 32'h0000_6381);

        // All anodes low: no capture, no glitch
        drive_raw(4'b0000, SEG_8, 30);
        check("alllow_glitch", 32'(gl_cnt), 32'd1);
        check("alllow_fv", 32'(fv_cnt), 32'd4);
        check("alllow_bcd", 32'(bcd_out), 32'h0000_6381);
        drive_raw(4'b1111, SEG_BLANK, 5);

        // Reset mid-frame discards the partial frame
        show(3, SEG_1, 20); show(2, SEG_1, 20); show(1, SEG_1, 20);
        drive_raw(4'b1111, SEG_BLANK, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_bcd", 32'(bcd_out), 32'h0000_FFFF);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        fv_base = fv_cnt;
        drive_raw(4'b1111, SEG_BLANK, 3);
        show(0, SEG_9, 20); show(3, SEG_9, 20); show(2, SEG_9, 20); show(1, SEG_9, 20);
        check("midrst_one_frame", 32'(fv_cnt - fv_base), 32'd1);
        check("midrst_bcd9999", 32'(bcd_out), 32'h0000_9999);

        // Blank pattern on digit 3
        show(3, SEG_BLANK, 20); show(2, SEG_1, 20); show(1, SEG_2, 20); show(0, SEG_3, 20);
        check("blank_fv_count", 32'(fv_cnt - fv_base), 32'd2);
`ifdef SEG_RX_BLANK_EN
        check("blank_bcd", 32'(bcd_out), 32'h0000_F123);
        check("blank_ferr", 32'(frame_err), 32'd0);
`else
        check("blank_bcd", 32'(bcd_out), 32'h0000_E123);
        check("blank_ferr", 32'(frame_err), 32'd1);
`endif
        check("final_glitch_total", 32'(gl_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
